// File: rtl/mul1_sweep_ctrl_pkg.sv
// Shared types and constants for the FastICA MUL1 sweep controller.
// Datapath format of MUL1 is 26-bit Q13; the controller itself only sequences it.
package fastica_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSNAP,
        RUN,
        FLUSH,
        WAIT_UPD,
        DONE
    } state_t;

    localparam int DATA_W       = 26;
    localparam int FRAC_W       = 13;
    localparam int CNT_W_DEF    = 16;
    localparam int ITER_W_DEF   = 8;
    localparam int MAX_ITER_DEF = 64;

endpackage

// File: rtl/mul1_sweep_ctrl_if.sv
// z-stream, MUL1 product flags and weight-update handshake between the
// sweep controller (master) and its upstream/downstream neighbours (slave).
interface mul1_sweep_ctrl_if;

    logic z_valid;
    logic z_ready;
    logic en_mul;
    logic prod_valid;
    logic prod_last;
    logic w_snap_valid;
    logic sweep_done;
    logic update_done;
    logic converged;

    modport master (
        input  z_valid, update_done, converged,
        output z_ready, en_mul, prod_valid, prod_last, w_snap_valid, sweep_done
    );

    modport slave (
        output z_valid, update_done, converged,
        input  z_ready, en_mul, prod_valid, prod_last, w_snap_valid, sweep_done
    );

endinterface

// File: rtl/mul1_sweep_ctrl_sweep_counter.sv
// Loadable up-counter with synchronous clear and terminal-count compare.
// Clear has priority over load, load over increment.
module sweep_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (inc)
            cnt <= cnt + W'(1);
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/mul1_sweep_ctrl.sv
// Sequences MUL1 for one-unit FastICA: per sweep a W snapshot cycle, a stream
// of z vectors, then a wait for the weight-update unit, until convergence.
module mul1_sweep_ctrl
    import fastica_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ITER_W   = ITER_W_DEF,
    parameter int MAX_ITER = MAX_ITER_DEF
) (
    input  logic              clk_mul,
    input  logic              rstn_mul,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  num_samples,
    mul1_sweep_ctrl_if.master mif,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [CNT_W-1:0]  sample_cnt
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_lat;
    logic             z_ready_c, en_mul_c, accept;
    logic             start_ok, smp_clr, upd_ev, finish_ev;
    logic             smp_tc, itr_tc;

    logic             prod_valid_p1, prod_last_p1, w_snap_valid_p1, sweep_done_p1;

    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        z_ready_c = 1'b0;
        en_mul_c  = 1'b0;
        start_ok  = 1'b0;
        smp_clr   = 1'b0;
        upd_ev    = 1'b0;
        finish_ev = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WSNAP;
                    start_ok  = 1'b1;
                end
            end
            WSNAP: begin
                smp_clr   = 1'b1;
                state_nxt = (num_lat == '0) ? FLUSH : RUN;
            end
            RUN: begin
                z_ready_c = 1'b1;
                en_mul_c  = mif.z_valid;
                if (mif.z_valid && smp_tc)
                    state_nxt = FLUSH;
            end
            FLUSH: state_nxt = WAIT_UPD;
            WAIT_UPD: begin
                if (mif.update_done) begin
                    upd_ev = 1'b1;
                    if (mif.converged || itr_tc) begin
                        finish_ev = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WSNAP;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything, including a start arriving in the same cycle
        if (abort) begin
            state_nxt = IDLE;
            z_ready_c = 1'b0;
            en_mul_c  = 1'b0;
            start_ok  = 1'b0;
            smp_clr   = 1'b0;
            upd_ev    = 1'b0;
            finish_ev = 1'b0;
        end
    end

    assign accept = z_ready_c & mif.z_valid;

    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul)
            num_lat <= '0;
        else if (abort)
            num_lat <= '0;
        else if (start_ok)
            num_lat <= num_samples;
    end

    sweep_counter #(.W(CNT_W)) u_smp_cnt (
        .clk      (clk_mul),
        .rst_n    (rstn_mul),
        .clr      (smp_clr | abort),
        .load     (1'b0),
        .load_val ('0),
        .inc      (accept),
        .tc_val   (num_lat - CNT_W'(1)),
        .cnt      (sample_cnt),
        .tc       (smp_tc)
    );

    sweep_counter #(.W(ITER_W)) u_itr_cnt (
        .clk      (clk_mul),
        .rst_n    (rstn_mul),
        .clr      (start_ok | abort),
        .load     (1'b0),
        .load_val ('0),
        .inc      (upd_ev),
        .tc_val   (ITER_W'(MAX_ITER - 1)),
        .cnt      (iter_cnt),
        .tc       (itr_tc)
    );

    // Stage p1: flags line up with MUL1's output register
    always_ff @(posedge clk_mul or negedge rstn_mul) begin
        if (!rstn_mul) begin
            prod_valid_p1   <= 1'b0;
            prod_last_p1    <= 1'b0;
            w_snap_valid_p1 <= 1'b0;
            sweep_done_p1   <= 1'b0;
            timeout         <= 1'b0;
        end else if (abort) begin
            prod_valid_p1   <= 1'b0;
            prod_last_p1    <= 1'b0;
            w_snap_valid_p1 <= 1'b0;
            sweep_done_p1   <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            prod_valid_p1   <= en_mul_c;
            prod_last_p1    <= accept & smp_tc;
            w_snap_valid_p1 <= (state == WSNAP);
            sweep_done_p1   <= (state == FLUSH);
            if (start_ok)
                timeout <= 1'b0;
            else if (finish_ev)
                timeout <= ~mif.converged;
        end
    end

    assign mif.z_ready      = z_ready_c;
    assign mif.en_mul       = en_mul_c;
    assign mif.prod_valid   = prod_valid_p1;
    assign mif.prod_last    = prod_last_p1;
    assign mif.w_snap_valid = w_snap_valid_p1;
    assign mif.sweep_done   = sweep_done_p1;

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_mul1_sweep_ctrl.sv
// Randomized bench for mul1_sweep_ctrl: expected per-cycle timelines are built
// from sweep-level rules, then replayed against two DUTs (MAX_ITER 64 and 2).
module tb_mul1_sweep_ctrl;

    localparam int CNT_W  = 16;
    localparam int ITER_W = 8;
    localparam int MAXC   = 1024;

    logic clk_mul = 1'b0;
    always #5 clk_mul = ~clk_mul;

    logic             rstn_mul, start, abort, zv, ud, cv, sel;
    logic [CNT_W-1:0] num_samples;

    mul1_sweep_ctrl_if ifa ();
    mul1_sweep_ctrl_if ifb ();

    assign ifa.z_valid = zv;  assign ifa.update_done = ud;  assign ifa.converged = cv;
    assign ifb.z_valid = zv;  assign ifb.update_done = ud;  assign ifb.converged = cv;

    logic              busy_a, done_a, to_a, busy_b, done_b, to_b;
    logic [ITER_W-1:0] it_a, it_b;
    logic [CNT_W-1:0]  sc_a, sc_b;

    mul1_sweep_ctrl #(.CNT_W(CNT_W), .ITER_W(ITER_W), .MAX_ITER(64)) dut_a (
        .clk_mul(clk_mul), .rstn_mul(rstn_mul), .start(start), .abort(abort),
        .num_samples(num_samples), .mif(ifa), .busy(busy_a), .done(done_a),
        .timeout(to_a), .iter_cnt(it_a), .sample_cnt(sc_a)
    );

    mul1_sweep_ctrl #(.CNT_W(CNT_W), .ITER_W(ITER_W), .MAX_ITER(2)) dut_b (
        .clk_mul(clk_mul), .rstn_mul(rstn_mul), .start(start), .abort(abort),
        .num_samples(num_samples), .mif(ifb), .busy(busy_b), .done(done_b),
        .timeout(to_b), .iter_cnt(it_b), .sample_cnt(sc_b)
    );

    logic              o_zr, o_en, o_pv, o_pl, o_ws, o_sd, o_busy, o_done, o_to;
    logic [ITER_W-1:0] o_it;
    logic [CNT_W-1:0]  o_sc;

    always_comb begin
        o_zr   = sel ? ifb.z_ready      : ifa.z_ready;
        o_en   = sel ? ifb.en_mul       : ifa.en_mul;
        o_pv   = sel ? ifb.prod_valid   : ifa.prod_valid;
        o_pl   = sel ? ifb.prod_last    : ifa.prod_last;
        o_ws   = sel ? ifb.w_snap_valid : ifa.w_snap_valid;
        o_sd   = sel ? ifb.sweep_done   : ifa.sweep_done;
        o_busy = sel ? busy_b : busy_a;
        o_done = sel ? done_b : done_a;
        o_to   = sel ? to_b   : to_a;
        o_it   = sel ? it_b   : it_a;
        o_sc   = sel ? sc_b   : sc_a;
    end

    int checks = 0;
    int errors = 0;

    // Expected timeline and input plan, indexed by cycle relative to start
    bit e_zr[MAXC], e_en[MAXC], e_pv[MAXC], e_pl[MAXC], e_ws[MAXC], e_sd[MAXC];
    bit e_busy[MAXC], e_done[MAXC], e_to[MAXC];
    int e_it[MAXC], e_sc[MAXC];
    bit zv_p[MAXC], ud_p[MAXC], cv_p[MAXC];

    // Visible state each DUT was left in by its previous checked run
    int p_done[2], p_to[2], p_it[2], p_sc[2];

    task automatic abort_all();
        start = 1'b0; abort = 1'b1; zv = 1'b0; ud = 1'b0; cv = 1'b0;
        @(posedge clk_mul); #1;
        abort = 1'b0;
        @(posedge clk_mul); #1;
        for (int i = 0; i < 2; i++) begin
            p_done[i] = 0; p_to[i] = 0; p_it[i] = 0; p_sc[i] = 0;
        end
    endtask

    task automatic run_check(input string name, input bit dsel, input int n, input int prob,
                             input bit use_pat, input int conv_at, input int max_iter);
        int s, c, a, d, u, it, sweep, pi, sc, last_k;
        bit conv, ovf;
        logic [5:0] pat;
        pat = 6'b101101;
        for (int i = 0; i < MAXC; i++) begin
            e_zr[i] = 0; e_en[i] = 0; e_pv[i] = 0; e_pl[i] = 0; e_ws[i] = 0; e_sd[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_to[i] = 0; e_it[i] = 0; e_sc[i] = 0;
            zv_p[i] = 1'($urandom_range(1)); ud_p[i] = 1'($urandom_range(1));
            cv_p[i] = 1'($urandom_range(1));
        end
        sel = dsel;
        e_done[0] = 1'(p_done[dsel]); e_to[0] = 1'(p_to[dsel]);
        e_it[0] = p_it[dsel]; e_sc[0] = p_sc[dsel];
        it = 0; sc = p_sc[dsel]; s = 1; sweep = 0; ovf = 0; conv = 0; a = 0; u = 0;
        forever begin
            if (s > MAXC - 64) begin ovf = 1; break; end
            // snapshot cycle
            e_busy[s] = 1; e_it[s] = it; e_sc[s] = sc;
            e_ws[s + 1] = 1;
            a = 0; c = s + 1; pi = 0;
            while (a < n) begin
                if (c > MAXC - 64) begin ovf = 1; break; end
                if (use_pat) begin zv_p[c] = pat[pi % 6]; pi++; end
                else zv_p[c] = ($urandom_range(99) < prob);
                e_busy[c] = 1; e_it[c] = it; e_sc[c] = a; e_zr[c] = 1; e_en[c] = zv_p[c];
                if (zv_p[c]) begin
                    e_pv[c + 1] = 1;
                    a++;
                    if (a == n) e_pl[c + 1] = 1;
                end
                c++;
            end
            if (ovf) break;
            // flush cycle, then wait for the weight update
            e_busy[c] = 1; e_it[c] = it; e_sc[c] = a;
            e_sd[c + 1] = 1;
            d = $urandom_range(3);
            conv = (sweep + 1 == conv_at);
            for (int j = 0; j <= d; j++) begin
                e_busy[c + 1 + j] = 1; e_it[c + 1 + j] = it; e_sc[c + 1 + j] = a;
                ud_p[c + 1 + j] = (j == d);
                if (j == d) cv_p[c + 1 + j] = conv;
            end
            u = c + 1 + d;
            it++; sweep++; sc = a;
            if (conv || it == max_iter) break;
            s = u + 1;
        end
        if (ovf) begin
            checks++; errors++;
            $display("FAIL %s plan_overflow: got cycle>%0d required <=%0d", name, MAXC - 64, MAXC - 64);
            return;
        end
        for (int k = u + 1; k <= u + 4; k++) begin
            e_done[k] = 1; e_to[k] = !conv; e_it[k] = it; e_sc[k] = a;
        end
        last_k = u + 4;

        for (int k = 0; k <= last_k; k++) begin
            start = (k == 0); abort = 1'b0;
            zv = zv_p[k]; ud = ud_p[k]; cv = cv_p[k];
            num_samples = (k == 0) ? CNT_W'(n) : CNT_W'($urandom);
            #1;
            checks += 11;
            if (o_zr !== e_zr[k]) begin errors++; $display("FAIL %s z_ready cyc %0d: got %b exp %b", name, k, o_zr, e_zr[k]); end
            if (o_en !== e_en[k]) begin errors++; $display("FAIL %s en_mul cyc %0d: got %b exp %b", name, k, o_en, e_en[k]); end
            if (o_pv !== e_pv[k]) begin errors++; $display("FAIL %s prod_valid cyc %0d: got %b exp %b", name, k, o_pv, e_pv[k]); end
            if (o_pl !== e_pl[k]) begin errors++; $display("FAIL %s prod_last cyc %0d: got %b exp %b", name, k, o_pl, e_pl[k]); end
            if (o_ws !== e_ws[k]) begin errors++; $display("FAIL %s w_snap_valid cyc %0d: got %b exp %b", name, k, o_ws, e_ws[k]); end
            if (o_sd !== e_sd[k]) begin errors++; $display("FAIL %s sweep_done cyc %0d: got %b exp %b", name, k, o_sd, e_sd[k]); end
            if (o_busy !== e_busy[k]) begin errors++; $display("FAIL %s busy cyc %0d: got %b exp %b", name, k, o_busy, e_busy[k]); end
            if (o_done !== e_done[k]) begin errors++; $display("FAIL %s done cyc %0d: got %b exp %b", name, k, o_done, e_done[k]); end
            if (o_to !== e_to[k]) begin errors++; $display("FAIL %s timeout cyc %0d: got %b exp %b", name, k, o_to, e_to[k]); end
            if (o_it !== ITER_W'(e_it[k])) begin errors++; $display("FAIL %s iter_cnt cyc %0d: got %0d exp %0d", name, k, o_it, e_it[k]); end
            if (o_sc !== CNT_W'(e_sc[k])) begin errors++; $display("FAIL %s sample_cnt cyc %0d: got %0d exp %0d", name, k, o_sc, e_sc[k]); end
            @(posedge clk_mul); #1;
        end
        start = 1'b0;
        p_done[dsel] = 1; p_to[dsel] = int'(!conv); p_it[dsel] = it; p_sc[dsel] = a;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #2;
        checks += 3;
        if ({ifa.z_ready, ifa.en_mul, ifa.prod_valid, ifa.prod_last, ifa.w_snap_valid,
             ifa.sweep_done, busy_a, done_a, to_a} !== 9'b0) begin
            errors++; $display("FAIL reset_flags: got %b exp 0", {ifa.z_ready, ifa.en_mul,
                ifa.prod_valid, ifa.prod_last, ifa.w_snap_valid, ifa.sweep_done, busy_a, done_a, to_a});
        end
        if (it_a !== '0) begin errors++; $display("FAIL reset_iter_cnt: got %0d exp 0", it_a); end
        if (sc_a !== '0) begin errors++; $display("FAIL reset_sample_cnt: got %0d exp 0", sc_a); end
        rstn_mul = 1'b1;
        @(posedge clk_mul); #1;
        abort_all();
    endtask

    task automatic test_stream_full();
        abort_all();
        run_check("stream_full", 1'b0, 4, 100, 1'b0, 1, 64);
    endtask

    task automatic test_bubbles();
        abort_all();
        run_check("bubbles", 1'b0, 4, 0, 1'b1, 1, 64);
    endtask

    task automatic test_converge();
        abort_all();
        run_check("converge3", 1'b0, 3, 70, 1'b0, 3, 64);
    endtask

    task automatic test_timeout();
        abort_all();
        run_check("timeout", 1'b1, 3, 60, 1'b0, 0, 2);
    endtask

    task automatic test_back_to_back();
        run_check("restart_from_done", 1'b1, 2, 80, 1'b0, 1, 2);
    endtask

    task automatic test_zero_samples();
        abort_all();
        run_check("zero_samples", 1'b0, 0, 100, 1'b0, 2, 64);
    endtask

    task automatic test_async_reset_mid_run();
        abort_all();
        sel = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = (k == 0); num_samples = CNT_W'(8); zv = 1'b1; ud = 1'b0; cv = 1'b0;
            @(posedge clk_mul); #1;
        end
        start = 1'b0;
        #1;
        checks++;
        if (sc_a !== CNT_W'(3)) begin errors++; $display("FAIL pre_reset_sample_cnt: got %0d exp 3", sc_a); end
        rstn_mul = 1'b0;
        #1;
        checks += 3;
        if ({ifa.z_ready, ifa.en_mul, ifa.prod_valid, ifa.prod_last, ifa.w_snap_valid,
             ifa.sweep_done, busy_a, done_a, to_a} !== 9'b0) begin
            errors++; $display("FAIL midrun_reset_flags: got %b exp 0", {ifa.z_ready, ifa.en_mul,
                ifa.prod_valid, ifa.prod_last, ifa.w_snap_valid, ifa.sweep_done, busy_a, done_a, to_a});
        end
        if (it_a !== '0) begin errors++; $display("FAIL midrun_reset_iter_cnt: got %0d exp 0", it_a); end
        if (sc_a !== '0) begin errors++; $display("FAIL midrun_reset_sample_cnt: got %0d exp 0", sc_a); end
        #1;
        rstn_mul = 1'b1;
        @(posedge clk_mul); #1;
        for (int i = 0; i < 2; i++) begin
            p_done[i] = 0; p_to[i] = 0; p_it[i] = 0; p_sc[i] = 0;
        end
        run_check("fresh_after_reset", 1'b0, 3, 100, 1'b0, 1, 64);
    endtask

    task automatic test_abort_start();
        abort_all();
        sel = 1'b0;
        for (int k = 0; k < 4; k++) begin
            start = (k == 0); num_samples = CNT_W'(8); zv = 1'b1; ud = 1'b0; cv = 1'b0;
            @(posedge clk_mul); #1;
        end
        start = 1'b1; abort = 1'b1;
        @(posedge clk_mul); #1;
        start = 1'b0; abort = 1'b0;
        for (int k = 0; k < 5; k++) begin
            zv = 1'b1;
            #1;
            checks += 4;
            if (o_en !== 1'b0) begin errors++; $display("FAIL abort_en_mul cyc %0d: got %b exp 0", k, o_en); end
            if (o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy cyc %0d: got %b exp 0", k, o_busy); end
            if (o_pv !== 1'b0) begin errors++; $display("FAIL abort_prod_valid cyc %0d: got %b exp 0", k, o_pv); end
            if (o_sc !== '0) begin errors++; $display("FAIL abort_sample_cnt cyc %0d: got %0d exp 0", k, o_sc); end
            @(posedge clk_mul); #1;
        end
        zv = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            abort_all();
            run_check("random", 1'b0, $urandom_range(6, 1), 55, 1'b0, $urandom_range(3, 1), 64);
        end
    endtask

    initial begin
        rstn_mul = 1'b0; start = 1'b0; abort = 1'b0; zv = 1'b0; ud = 1'b0; cv = 1'b0;
        num_samples = '0; sel = 1'b0;
        test_reset();
        test_stream_full();
        test_bubbles();
        test_converge();
        test_timeout();
        test_back_to_back();
        test_zero_samples();
        test_async_reset_mid_run();
        test_abort_start();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 required earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
